evt_output_buffer: RTL

- First-word-fall-through (FWFT) event output FIFO between the event builder and the fiber event handler.
- The event builder writes 32-bit event words. The fiber side reads with a look-ahead handshake: data is valid whenever EMPTY=0, and RD_EN pops it.
- Tracks complete blocks stored (trailer words, data[31:27]=5'b10001) and provides status for the OBUF status register space.

---
 rtl/evt_output_buffer_if.sv | 27 ++
 rtl/evt_output_buffer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/evt_output_buffer_if.sv
// Event output buffer bus: builder write port, fiber look-ahead read port and status.
// master drives writes/pops; slave is the buffer itself.
interface evt_output_buffer_if #(
    parameter int DEPTH_LOG2 = 11
);
    logic [31:0]         WR_DATA;
    logic                WR_EN;
    logic                FULL;
    logic                ALMOST_FULL;
    logic [31:0]         RD_DATA;
    logic                RD_EN;
    logic                EMPTY;
    logic [DEPTH_LOG2:0] WORD_COUNT;
    logic [DEPTH_LOG2:0] BLOCK_COUNT;
    logic                OVERFLOW;
    logic                UNDERFLOW;

    modport master (
        output WR_DATA, WR_EN, RD_EN,
        input  FULL, ALMOST_FULL, RD_DATA, EMPTY, WORD_COUNT, BLOCK_COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  WR_DATA, WR_EN, RD_EN,
        output FULL, ALMOST_FULL, RD_DATA, EMPTY, WORD_COUNT, BLOCK_COUNT, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/evt_output_buffer.sv
// FWFT event output FIFO: sync-read RAM -> prefetch register -> output register.
// Define OBUF_BLOCK_GATE_EN to hold EMPTY until a complete block (trailer) is stored.
module evt_output_buffer #(
    parameter int DEPTH_LOG2 = 11,
    parameter int AF_MARGIN  = 64
) (
    input  logic                  CLK,
    input  logic                  RSTb,
    input  logic                  CLEAR,
    evt_output_buffer_if.slave    bus
);
    localparam int C        = 1 << DEPTH_LOG2;
    localparam int AF_LEVEL = (C > AF_MARGIN) ? (C - AF_MARGIN) : 0;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam cnt_t CAP = cnt_t'(C);

    logic [31:0] mem [C];
    logic [31:0] pf_data_q;

    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    cnt_t        word_count_q, word_count_d;
    cnt_t        block_count_q, block_count_d;
    logic        out_valid_q, out_valid_d;
    logic        pf_valid_q, pf_valid_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;

    logic        full, almost_full, empty_int, empty;
    logic        push, pop, mem_we, rd_issue, out_load;
    logic        push_trl, pop_trl;
    cnt_t        ram_count;

    assign full        = (word_count_q == CAP);
    assign almost_full = (32'(word_count_q) >= 32'(AF_LEVEL));
    assign empty_int   = ~out_valid_q;

`ifdef OBUF_BLOCK_GATE_EN
    // FULL releases the gate so a block longer than the buffer cannot deadlock.
    assign empty = empty_int | ((block_count_q == '0) & ~full);
`else
    assign empty = empty_int;
`endif

    always_comb begin
        push      = bus.WR_EN & ~full;
        pop       = bus.RD_EN & ~empty;
        mem_we    = push & ~CLEAR;
        push_trl  = push & (bus.WR_DATA[31:27] == 5'b10001);
        pop_trl   = pop & (rd_data_q[31:27] == 5'b10001);
        // Words still in RAM = total minus those already lifted into the two registers.
        ram_count = word_count_q - cnt_t'(out_valid_q) - cnt_t'(pf_valid_q);
        out_load  = ~out_valid_q | pop;
        rd_issue  = (ram_count != '0) & (~pf_valid_q | out_load);

        wr_ptr_d      = wr_ptr_q + ptr_t'(push);
        rd_ptr_d      = rd_ptr_q + ptr_t'(rd_issue);
        word_count_d  = word_count_q + cnt_t'(push) - cnt_t'(pop);
        block_count_d = block_count_q + cnt_t'(push_trl) - cnt_t'(pop_trl);
        pf_valid_d    = rd_issue ? 1'b1 : (out_load ? 1'b0 : pf_valid_q);
        out_valid_d   = out_load ? pf_valid_q : out_valid_q;
        rd_data_d     = (out_load & pf_valid_q) ? pf_data_q : rd_data_q;
        overflow_d    = overflow_q | (bus.WR_EN & full);
        underflow_d   = underflow_q | (bus.RD_EN & empty);

        if (CLEAR) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            word_count_d  = '0;
            block_count_d = '0;
            pf_valid_d    = 1'b0;
            out_valid_d   = 1'b0;
            rd_data_d     = rd_data_q;
            overflow_d    = 1'b0;
            underflow_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) mem[wr_ptr_q] <= bus.WR_DATA;
        if (rd_issue) pf_data_q <= mem[rd_ptr_q];
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            word_count_q  <= '0;
            block_count_q <= '0;
            pf_valid_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            rd_data_q     <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            word_count_q  <= word_count_d;
            block_count_q <= block_count_d;
            pf_valid_q    <= pf_valid_d;
            out_valid_q   <= out_valid_d;
            rd_data_q     <= rd_data_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    assign bus.FULL        = full;
    assign bus.ALMOST_FULL = almost_full;
    assign bus.EMPTY       = empty;
    assign bus.RD_DATA     = rd_data_q;
    assign bus.WORD_COUNT  = word_count_q;
    assign bus.BLOCK_COUNT = block_count_q;
    assign bus.OVERFLOW    = overflow_q;
    assign bus.UNDERFLOW   = underflow_q;
endmodule
